// File: rtl/ysyx_210544_axi_rw_pkg.sv
// Shared constants for the AXI4 read/write bridge: beat sizes, burst encoding,
// FSM states and the narrow-beat byte mask helper.
package ysyx_210544_axi_rw_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5
   } state_e;

   // (1 << size) contiguous byte enables starting at the byte offset
   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] base;
      case (size)
         SIZE_B:  base = 8'h01;
         SIZE_H:  base = 8'h03;
         SIZE_W:  base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

endpackage

// File: rtl/ysyx_210544_axi_rw_lane.sv
// Byte-lane steering for the bridge: write strobe, write data alignment and
// read data extraction for beats narrower than 64 bits.
module ysyx_210544_axi_lane
   import ysyx_210544_axi_rw_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [2:0]  offset,
   input  logic [63:0] wbeat,
   input  logic [63:0] rbeat,
   output logic [7:0]  wstrb,
   output logic [63:0] wdata,
   output logic [63:0] rword
);

   logic [5:0] shamt;
   logic       narrow;

   assign shamt  = {offset, 3'b000};
   assign narrow = (size != SIZE_D);

   always_comb begin
      wstrb = 8'hFF;
      wdata = wbeat;
      rword = rbeat;
      if (narrow) begin
         wstrb = byte_mask(size, offset);
         wdata = wbeat << shamt;
         rword = rbeat >> shamt;
      end
   end

endmodule

// File: rtl/ysyx_210544_axi_rw.sv
// AXI4 master bridge: one io request at a time turned into an INCR burst of up
// to 8 x 64-bit beats. Optional response-error output under YSYX_210544_AXI_ERR_EN.
module ysyx_210544_axi_rw
   import ysyx_210544_axi_rw_pkg::*;
#(
   parameter int AXI_ID_W = 4,
   parameter int AXI_ID   = 0
)(
   input  logic                clk,
   input  logic                rst,

   input  logic                i_axi_io_valid,
   input  logic                i_axi_io_op,
   input  logic [63:0]         i_axi_io_addr,
   input  logic [1:0]          i_axi_io_size,
   input  logic [7:0]          i_axi_io_blks,
   input  logic [511:0]        i_axi_io_wdata,
   output logic                o_axi_io_ready,
   output logic [511:0]        o_axi_io_rdata,
`ifdef YSYX_210544_AXI_ERR_EN
   output logic                o_axi_io_err,
`endif

   output logic                o_awvalid,
   input  logic                i_awready,
   output logic [63:0]         o_awaddr,
   output logic [AXI_ID_W-1:0] o_awid,
   output logic [7:0]          o_awlen,
   output logic [2:0]          o_awsize,
   output logic [1:0]          o_awburst,

   output logic                o_wvalid,
   input  logic                i_wready,
   output logic [63:0]         o_wdata,
   output logic [7:0]          o_wstrb,
   output logic                o_wlast,

   input  logic                i_bvalid,
   output logic                o_bready,
   input  logic [1:0]          i_bresp,
   input  logic [AXI_ID_W-1:0] i_bid,

   output logic                o_arvalid,
   input  logic                i_arready,
   output logic [63:0]         o_araddr,
   output logic [AXI_ID_W-1:0] o_arid,
   output logic [7:0]          o_arlen,
   output logic [2:0]          o_arsize,
   output logic [1:0]          o_arburst,

   input  logic                i_rvalid,
   output logic                o_rready,
   input  logic [63:0]         i_rdata,
   input  logic [1:0]          i_rresp,
   input  logic                i_rlast,
   input  logic [AXI_ID_W-1:0] i_rid
);

   state_e         state;
   logic [2:0]     cnt;
   logic           ready_d;
   logic [63:0]    addr_q;
   logic [1:0]     size_q;
   logic [7:0]     blks_q;
   logic [511:0]   wdata_q;
   logic [511:0]   rbuf;
   logic [511:0]   rbuf_next;
   logic [63:0]    wbeat;
   logic [63:0]    rword;
   logic           accept;
   logic           last_cnt;
   logic           unused_ok;

   // Upstream keeps valid high during the ready cycle and the one after it
   assign accept   = (state == ST_IDLE) && i_axi_io_valid && !o_axi_io_ready && !ready_d;
   assign last_cnt = ({5'd0, cnt} == blks_q);
   assign wbeat    = wdata_q[{cnt, 6'd0} +: 64];

   ysyx_210544_axi_lane u_lane (
      .size   (size_q),
      .offset (addr_q[2:0]),
      .wbeat  (wbeat),
      .rbeat  (i_rdata),
      .wstrb  (o_wstrb),
      .wdata  (o_wdata),
      .rword  (rword)
   );

   always_comb begin
      rbuf_next = rbuf;
      rbuf_next[{cnt, 6'd0} +: 64] = rword;
   end

   assign o_araddr  = addr_q;
   assign o_arid    = AXI_ID_W'(AXI_ID);
   assign o_arlen   = blks_q;
   assign o_arsize  = {1'b0, size_q};
   assign o_arburst = AXI_BURST_INCR;

   assign o_awaddr  = addr_q;
   assign o_awid    = AXI_ID_W'(AXI_ID);
   assign o_awlen   = blks_q;
   assign o_awsize  = {1'b0, size_q};
   assign o_awburst = AXI_BURST_INCR;

   assign o_wlast   = last_cnt;

`ifdef YSYX_210544_AXI_ERR_EN
   assign unused_ok = ^{i_bid, i_rid, addr_q[63:3]};
`else
   assign unused_ok = ^{i_bid, i_rid, i_rresp, i_bresp, addr_q[63:3]};
`endif

   // Request fields are pure data and need no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= i_axi_io_addr;
         size_q  <= i_axi_io_size;
         blks_q  <= i_axi_io_blks;
         wdata_q <= i_axi_io_wdata;
      end
   end

   // Read gather buffer; starts clean for every request so short bursts read zeros above
   always_ff @(posedge clk) begin
      if (accept) begin
         rbuf <= '0;
      end else if ((state == ST_R) && i_rvalid) begin
         rbuf <= rbuf_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         cnt            <= 3'd0;
         ready_d        <= 1'b0;
         o_axi_io_ready <= 1'b0;
         o_axi_io_rdata <= '0;
         o_arvalid      <= 1'b0;
         o_rready       <= 1'b0;
         o_awvalid      <= 1'b0;
         o_wvalid       <= 1'b0;
         o_bready       <= 1'b0;
`ifdef YSYX_210544_AXI_ERR_EN
         o_axi_io_err   <= 1'b0;
`endif
      end else begin
         o_axi_io_ready <= 1'b0;
         ready_d        <= o_axi_io_ready;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cnt <= 3'd0;
`ifdef YSYX_210544_AXI_ERR_EN
                  o_axi_io_err <= 1'b0;
`endif
                  if (i_axi_io_op) begin
                     o_awvalid <= 1'b1;
                     state     <= ST_AW;
                  end else begin
                     o_arvalid <= 1'b1;
                     state     <= ST_AR;
                  end
               end
            end
            ST_AR: begin
               if (i_arready) begin
                  o_arvalid <= 1'b0;
                  o_rready  <= 1'b1;
                  state     <= ST_R;
               end
            end
            ST_R: begin
               if (i_rvalid) begin
                  cnt <= cnt + 3'd1;
`ifdef YSYX_210544_AXI_ERR_EN
                  if (i_rresp != 2'b00) o_axi_io_err <= 1'b1;
`endif
                  // An early rlast ends the burst just like reaching blks
                  if (i_rlast || last_cnt) begin
                     o_rready       <= 1'b0;
                     o_axi_io_ready <= 1'b1;
                     o_axi_io_rdata <= rbuf_next;
                     cnt            <= 3'd0;
                     state          <= ST_IDLE;
                  end
               end
            end
            ST_AW: begin
               if (i_awready) begin
                  o_awvalid <= 1'b0;
                  o_wvalid  <= 1'b1;
                  state     <= ST_W;
               end
            end
            ST_W: begin
               if (i_wready) begin
                  if (last_cnt) begin
                     o_wvalid <= 1'b0;
                     o_bready <= 1'b1;
                     cnt      <= 3'd0;
                     state    <= ST_B;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            ST_B: begin
               if (i_bvalid) begin
`ifdef YSYX_210544_AXI_ERR_EN
                  if (i_bresp != 2'b00) o_axi_io_err <= 1'b1;
`endif
                  o_bready       <= 1'b0;
                  o_axi_io_ready <= 1'b1;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
